seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-cathode seven-segment display. It latches a packed BCD word under a latch-enable, decodes one digit at a time into segment patterns and scans the digit selects at a prescaled rate. Lamp-test, blanking, leading-zero suppression and inter-digit dead time are built in. It sits between the counter/encoder datapaths and the board's multiplexed display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DIV, 1000, clk cycles per digit slot (>=2)
BLANK_CYC, 1, dead-time cycles at the start of each slot with all digits off (0..DIV-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
din  input  4*DIGITS  packed BCD; digit k = din[4k+3:4k], digit 0 is the LSD
dp_in  input  DIGITS  decimal point per digit
le  input  1  latch enable: 0 = capture din/dp_in every clk, 1 = hold
lt_n  input  1  lamp test, active low
bi_n  input  1  blanking, active low
lzb  input  1  1 = leading-zero blanking enabled
seg  output  8  segments: seg[0]=a .. seg[6]=g, seg[7]=dp, active high
dig_n  output  DIGITS  digit select, active low, one-hot-low
scan_tick  output  1  one-cycle pulse when the digit index advances

Behaviour:
- Reset (async, rst=1): data_q=0, dp_q=0, cnt=0, idx=0, bcnt=BLANK_CYC, seg=8'h00, dig_n=all ones, scan_tick=0.
- Latch: on every clk with le=0, data_q<=din and dp_q<=dp_in. With le=1, both hold. Decode always uses data_q, never din directly.
- Prescaler: tick = (cnt==DIV-1).
  - On tick: cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1, bcnt<=BLANK_CYC, scan_tick<=1.
  - Otherwise: cnt<=cnt+1, scan_tick<=0, and bcnt decrements if nonzero.
- Digit slot is exactly DIV cycles. The full frame is DIGITS*DIV cycles.
- Decode of data_q digit idx (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 decode to 00 (blank).
  - seg[7] = dp_q[idx].
- Leading-zero blanking: with lzb=1, digit k (k>=1) is blanked (seg=00, dp included) when it and every digit above it are 0. Digit 0 is never blanked by lzb. With lzb=0, nothing is suppressed.
- Priority per cycle: bcnt!=0 (dead time) > lt_n=0 > bi_n=0 > lzb suppression > normal decode.
  - Dead time: dig_n=all ones, seg=00.
  - lt_n=0: dig_n active for idx, seg=FF.
  - bi_n=0: dig_n active for idx, seg=00.
- Outputs are registered. seg and dig_n reflect the cnt/idx/bcnt/data_q/control state of the previous cycle (1-cycle latency). lt_n, bi_n and lzb are sampled by the output register directly.
- Active digit: dig_n[idx]=0, all other bits 1. Never more than one bit low.
- Simultaneous le=0 and data change during a slot: the new value appears on seg one cycle after it is latched (2 cycles from din), mid-slot.
- After rst deasserts, the first BLANK_CYC slot cycles are dark, then digit 0 is driven.
- Reset mid-scan restarts from digit 0 and clears latched data.

Test Plan (DIGITS=4, DIV=4, BLANK_CYC=1):
- Reset release with le=0, din=16'h1234, lzb=0 -> dig_n cycles 1110,1101,1011,0111 with 4-cycle slots, first cycle of each slot dig_n=1111. Segment pattern per slot: 66, 4F, 5B, 06. scan_tick pulses every 4 cycles.
- le=0 latches 16'h0059, then le=1 and din=16'h9999 -> display stays 0059. With lzb=1, digits 2 and 3 show seg=00 while digits 1 and 0 show 6D and 6F. Data 16'h0000 with lzb=1 -> digit 0 shows 3F, others 00.
- lt_n=0 with bi_n=0 -> seg=FF in every non-dead cycle, and dig_n still scans. lt_n=1, bi_n=0 -> seg=00 and dig_n still scans.
- din=16'hFA00 with dp_in=4'b0100 -> digits 3 and 2 seg=00 except digit 2 seg=80 (dp). Digits 1 and 0 seg=3F.
- Assert rst mid-slot at idx=2 -> seg=00 and dig_n=1111 immediately (async). After release, scan resumes at digit 0 with data 0 (seg=3F).
- Check the one-hot-low invariant on dig_n and the 1-cycle seg/dig_n latency against a reference model over 3 full frames.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-cathode seven-segment driver.
// Latches a packed BCD word, scans one digit per DIV-cycle slot with a short
// dead time at the start of each slot, and supports lamp test, blanking and
// leading-zero suppression. seg/dig_n/scan_tick are all registered outputs.
module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  le,
    input  logic                  lt_n,
    input  logic                  bi_n,
    input  logic                  lzb,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  scan_tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_INIT = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX    = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_bcnt;
    logic [IW-1:0]       r_idx;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_n;
    logic                r_scan_tick;

    logic                w_tick;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_digit;
    logic                w_dp;
    logic                w_lz_sel;
    logic [7:0]          w_seg_nxt;
    logic [DIGITS-1:0]   w_dig_nxt;

    // BCD to gfedcba segment pattern; non-decimal codes are dark
    function automatic logic [6:0] f_decode(input logic [3:0] bcd);
        logic [6:0] v;
        case (bcd)
            4'd0:    v = 7'h3F;
            4'd1:    v = 7'h06;
            4'd2:    v = 7'h5B;
            4'd3:    v = 7'h4F;
            4'd4:    v = 7'h66;
            4'd5:    v = 7'h6D;
            4'd6:    v = 7'h7D;
            4'd7:    v = 7'h07;
            4'd8:    v = 7'h7F;
            4'd9:    v = 7'h6F;
            default: v = 7'h00;
        endcase
        return v;
    endfunction

    assign w_tick = (r_cnt == CNT_MAX);

    // Transparent-low data latch: capture every cycle unless le holds it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_dp   <= '0;
        end else if (!le) begin
            r_data <= din;
            r_dp   <= dp_in;
        end else begin
            r_data <= r_data;
            r_dp   <= r_dp;
        end
    end

    // Slot prescaler, digit index and dead-time counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_bcnt      <= BLANK_INIT;
            r_scan_tick <= 1'b0;
        end else if (w_tick) begin
            r_cnt       <= '0;
            r_idx       <= (r_idx == IDX_MAX) ? IW'(0) : r_idx + IW'(1);
            r_bcnt      <= BLANK_INIT;
            r_scan_tick <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + CW'(1);
            r_bcnt      <= (r_bcnt != '0) ? r_bcnt - CW'(1) : r_bcnt;
            r_scan_tick <= 1'b0;
        end
    end

    // w_lz[k]: digit k and every digit above it are zero
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_lz         = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            v_zero_above = v_zero_above & (r_data[4*k +: 4] == 4'd0);
            w_lz[k]      = v_zero_above;
        end
    end

    // Select the currently scanned digit, its dp and its suppression flag
    always_comb begin
        w_digit  = 4'd0;
        w_dp     = 1'b0;
        w_lz_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            w_digit  = (r_idx == IW'(k)) ? r_data[4*k +: 4] : w_digit;
            w_dp     = (r_idx == IW'(k)) ? r_dp[k]          : w_dp;
            w_lz_sel = (r_idx == IW'(k)) ? w_lz[k]          : w_lz_sel;
        end
    end

    // Next display value: dead time > lamp test > blank > zero suppress > decode
    always_comb begin
        w_seg_nxt = 8'h00;
        w_dig_nxt = {DIGITS{1'b1}};
        if (r_bcnt != '0) begin
            w_seg_nxt = 8'h00;
            w_dig_nxt = {DIGITS{1'b1}};
        end else begin
            w_dig_nxt = ~(DIGITS'(1'b1) << r_idx);
            if (!lt_n) begin
                w_seg_nxt = 8'hFF;
            end else if (!bi_n) begin
                w_seg_nxt = 8'h00;
            end else if (lzb && (r_idx != IW'(0)) && w_lz_sel) begin
                w_seg_nxt = 8'h00;
            end else begin
                w_seg_nxt = {w_dp, f_decode(w_digit)};
            end
        end
    end

    // Output register so the display pins never see combinational glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= 8'h00;
            r_dig_n <= {DIGITS{1'b1}};
        end else begin
            r_seg   <= w_seg_nxt;
            r_dig_n <= w_dig_nxt;
        end
    end

    assign seg       = r_seg;
    assign dig_n     = r_dig_n;
    assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4, BLANK_CYC=1).
// The reference derives every output from the elapsed cycle count since reset
// (slot = t / DIV, position = t % DIV) and the latched data word.
module tb_seg7_scan_driver;
    localparam int DIGITS    = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        le;
    logic        lt_n;
    logic        bi_n;
    logic        lzb;
    logic [7:0]  seg;
    logic [3:0]  dig_n;
    logic        scan_tick;

    int nchk;
    int nerr;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .le(le),
        .lt_n(lt_n), .bi_n(bi_n), .lzb(lzb),
        .seg(seg), .dig_n(dig_n), .scan_tick(scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // Reference: segments for elapsed cycle t with latched data d
    function automatic logic [7:0] ref_seg(input int t, input logic [15:0] d,
                                           input logic [3:0] dp, input logic ltn,
                                           input logic bin, input logic lz);
        int pos;
        int idx;
        logic [15:0] above;
        pos   = t % DIV;
        idx   = (t / DIV) % DIGITS;
        above = d >> (4 * idx);
        if (pos < BLANK_CYC) return 8'h00;
        if (!ltn) return 8'hFF;
        if (!bin) return 8'h00;
        if (lz && idx > 0 && above == 16'h0000) return 8'h00;
        return {dp[idx], lut[above[3:0]]};
    endfunction

    function automatic logic [3:0] ref_dig(input int t);
        int idx;
        idx = (t / DIV) % DIGITS;
        if ((t % DIV) < BLANK_CYC) return 4'hF;
        return ~(4'b0001 << idx);
    endfunction

    int          m_t;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_tick;

    // Reference model, one output update per clock
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_data   <= 16'h0000;
            m_dp     <= 4'h0;
            exp_seg  <= 8'h00;
            exp_dig  <= 4'hF;
            exp_tick <= 1'b0;
        end else begin
            exp_seg  <= ref_seg(m_t, m_data, m_dp, lt_n, bi_n, lzb);
            exp_dig  <= ref_dig(m_t);
            exp_tick <= ((m_t % DIV) == DIV - 1);
            m_t      <= m_t + 1;
            if (!le) begin
                m_data <= din;
                m_dp   <= dp_in;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++; if (seg !== 8'h00) begin nerr++; $display("FAIL reset_seg: got %h want 00", seg); end
        nchk++; if (dig_n !== 4'hF) begin nerr++; $display("FAIL reset_dig: got %b want 1111", dig_n); end
        nchk++; if (scan_tick !== 1'b0) begin nerr++; $display("FAIL reset_tick: got %b want 0", scan_tick); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] tbl [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        int idx;
        for (int i = 0; i < 2 * DIGITS * DIV; i++) begin
            @(negedge clk);
            nchk++;
            if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                nerr++;
                $display("FAIL scan_model: seg=%h dig_n=%b tick=%b want seg=%h dig_n=%b tick=%b",
                         seg, dig_n, scan_tick, exp_seg, exp_dig, exp_tick);
            end
            if (dig_n !== 4'hF) begin
                idx = 0;
                for (int k = 0; k < DIGITS; k++) if (dig_n[k] == 1'b0) idx = k;
                nchk++;
                if (seg !== tbl[idx]) begin
                    nerr++;
                    $display("FAIL scan_digit%0d: seg=%h want %h", idx, seg, tbl[idx]);
                end
            end
        end
    endtask

    task automatic test_latch_lzb();
        logic [7:0] tbl_a [4] = '{8'h6F, 8'h6D, 8'h00, 8'h00};
        logic [7:0] tbl_b [4] = '{8'h3F, 8'h00, 8'h00, 8'h00};
        int idx;
        le = 1'b0; din = 16'h0059;
        @(negedge clk);
        le = 1'b1; din = 16'h9999; lzb = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DIGITS * DIV + 2; i++) begin
                @(negedge clk);
                nchk++;
                if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                    nerr++;
                    $display("FAIL lzb_model%0d: seg=%h dig_n=%b tick=%b want seg=%h dig_n=%b tick=%b",
                             pass, seg, dig_n, scan_tick, exp_seg, exp_dig, exp_tick);
                end
                if (i >= 2 && dig_n !== 4'hF) begin
                    idx = 0;
                    for (int k = 0; k < DIGITS; k++) if (dig_n[k] == 1'b0) idx = k;
                    nchk++;
                    if (seg !== ((pass == 0) ? tbl_a[idx] : tbl_b[idx])) begin
                        nerr++;
                        $display("FAIL lzb_digit%0d_pass%0d: seg=%h want %h", idx, pass, seg,
                                 (pass == 0) ? tbl_a[idx] : tbl_b[idx]);
                    end
                end
                if (pass == 0 && i == DIGITS * DIV + 1) begin
                    le = 1'b0; din = 16'h0000;
                end
            end
        end
        le = 1'b1;
    endtask

    task automatic test_lamp_blank();
        lt_n = 1'b0; bi_n = 1'b0; lzb = 1'b0;
        for (int i = 0; i < 2 * DIGITS * DIV; i++) begin
            @(negedge clk);
            nchk++;
            if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                nerr++;
                $display("FAIL lamp_model: seg=%h dig_n=%b want seg=%h dig_n=%b", seg, dig_n, exp_seg, exp_dig);
            end
            if (dig_n !== 4'hF) begin
                nchk++;
                if (seg !== ((i < DIGITS * DIV) ? 8'hFF : 8'h00)) begin
                    nerr++;
                    $display("FAIL lamp_blank_seg: seg=%h want %h", seg, (i < DIGITS * DIV) ? 8'hFF : 8'h00);
                end
            end
            if (i == DIGITS * DIV - 1) lt_n = 1'b1;
        end
        bi_n = 1'b1;
    endtask

    task automatic test_dp_invalid();
        logic [7:0] tbl [4] = '{8'h3F, 8'h3F, 8'h80, 8'h00};
        int idx;
        le = 1'b0; din = 16'hFA00; dp_in = 4'b0100;
        for (int i = 0; i < DIGITS * DIV + 2; i++) begin
            @(negedge clk);
            nchk++;
            if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                nerr++;
                $display("FAIL dp_model: seg=%h dig_n=%b want seg=%h dig_n=%b", seg, dig_n, exp_seg, exp_dig);
            end
            if (i >= 2 && dig_n !== 4'hF) begin
                idx = 0;
                for (int k = 0; k < DIGITS; k++) if (dig_n[k] == 1'b0) idx = k;
                nchk++;
                if (seg !== tbl[idx]) begin
                    nerr++;
                    $display("FAIL dp_digit%0d: seg=%h want %h", idx, seg, tbl[idx]);
                end
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        bit found;
        logic [3:0] first_dig;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig_n == 4'b1011) found = 1'b1;
        end
        nchk++; if (!found) begin nerr++; $display("FAIL rst_wait: dig_n never reached 1011"); end
        #2;
        le = 1'b1; rst = 1'b1;
        #1;
        nchk++; if (seg !== 8'h00) begin nerr++; $display("FAIL async_rst_seg: got %h want 00", seg); end
        nchk++; if (dig_n !== 4'hF) begin nerr++; $display("FAIL async_rst_dig: got %b want 1111", dig_n); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first_dig = 4'hF;
        for (int i = 0; i < DIGITS * DIV + 2; i++) begin
            @(negedge clk);
            nchk++;
            if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                nerr++;
                $display("FAIL post_rst_model: seg=%h dig_n=%b want seg=%h dig_n=%b", seg, dig_n, exp_seg, exp_dig);
            end
            if (dig_n !== 4'hF) begin
                if (first_dig == 4'hF) first_dig = dig_n;
                nchk++;
                if (seg !== 8'h3F) begin nerr++; $display("FAIL post_rst_seg: got %h want 3F", seg); end
            end
        end
        nchk++; if (first_dig !== 4'b1110) begin nerr++; $display("FAIL post_rst_first: got %b want 1110", first_dig); end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
        for (int i = 0; i < 3 * DIGITS * DIV; i++) begin
            @(negedge clk);
            nchk++;
            if ({seg, dig_n, scan_tick} !== {exp_seg, exp_dig, exp_tick}) begin
                nerr++;
                $display("FAIL rand_model: cyc=%0d seg=%h dig_n=%b tick=%b want seg=%h dig_n=%b tick=%b",
                         i, seg, dig_n, scan_tick, exp_seg, exp_dig, exp_tick);
            end
            nchk++;
            if (dig_n !== 4'hF && $countones(~dig_n) != 1) begin
                nerr++;
                $display("FAIL rand_onehot: dig_n=%b want at most one low bit", dig_n);
            end
            din   = 16'($urandom) & masks[$urandom_range(0, 3)];
            dp_in = 4'($urandom);
            le    = ($urandom_range(0, 3) == 0);
            lt_n  = ($urandom_range(0, 7) != 0);
            bi_n  = ($urandom_range(0, 7) != 0);
            lzb   = 1'($urandom);
        end
    endtask

    initial begin
        nchk = 0; nerr = 0;
        rst = 1'b1; le = 1'b0; din = 16'h1234; dp_in = 4'h0;
        lt_n = 1'b1; bi_n = 1'b1; lzb = 1'b0;
        test_reset();
        test_scan();
        test_latch_lzb();
        test_lamp_blank();
        test_dp_invalid();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
